masked_popcount_pipe: RTL and testbench
=======================================

// Module: masked_popcount_pipe
// PURPOSE
//  Streaming, pipelined successor to the combinational COUNT_ONES/pattern-select test logic.
//  Masks each input word with a compile-time bit PATTERN and counts the surviving ones,
//  CHUNK bits per pipeline stage.
//  Keeps a saturating running total of all counts delivered downstream.
//  Sits between a data source and a consumer on valid/ready streams.
// PARAMETERS
//  IN_WIDTH   32            input word width, >= 1
//  PATTERN    {IN_WIDTH{1}} IN_WIDTH-bit mask; only bits set here are counted
//  CHUNK      8             bits counted per stage, 1 <= CHUNK <= IN_WIDTH
//  ACC_WIDTH  16            running-total width, >= CNT_W
//  (derived)  STAGES = ceil(IN_WIDTH/CHUNK); CNT_W = $clog2(IN_WIDTH+1)
// PORTS
//  clk        in   1          clock, all state updates on posedge
//  rst        in   1          synchronous reset, active-high
//  in_valid   in   1          input word present
//  in_ready   out  1          pipeline accepts word this cycle
//  in_data    in   IN_WIDTH   input word
//  clear      in   1          synchronous clear of running total and sticky flag
//  out_valid  out  1          out_count valid
//  out_ready  in   1          consumer accepts out_count
//  out_count  out  CNT_W      popcount(in_data & PATTERN) of the head word
//  out_acc    out  ACC_WIDTH  saturating sum of all transferred out_count values
//  out_sat    out  1          sticky: out_acc has saturated since last clear/reset
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - all stage valids, partial sums, out_acc and out_sat go to 0
//   - in-flight words are discarded; in_ready = 1 on the first cycle after reset
//  Pipeline:
//   - STAGES register stages; stage k holds valid_k, the masked word and partial sum_k
//   - stage 0 loads (in_data & PATTERN) and sum = popcount(chunk 0)
//   - stage k adds popcount(chunk k), bits [k*CHUNK +: CHUNK]
//   - last chunk may be short; missing bits count as 0
//   - advance = !valid_{STAGES-1} || out_ready; on advance every stage shifts by one
//   - stage 0 takes valid = in_valid on advance
//   - bubbles are not collapsed
//  Outputs:
//   - in_ready = advance (combinational from out_ready and last-stage valid)
//   - transfer in: in_valid && in_ready
//   - transfer out: out_valid && out_ready
//   - out_valid/out_count come straight from the last stage's register
//   - latency: a word accepted at edge N appears on out_valid after edge N+STAGES-1,
//     i.e. STAGES cycles from in_valid to out_valid, with no stalls
//   - throughput: 1 word/cycle while out_ready = 1
//   - out_valid held: out_count stays stable and no word is lost or duplicated
//   - in_valid may drop at any time; stage 0 then fills with a bubble
//  Accumulator (registered; updated on transfer out):
//   - out_acc <= min(out_acc + out_count, 2^ACC_WIDTH-1)
//   - out_sat <= 1 when the unclamped sum >= 2^ACC_WIDTH-1; sticky
//   - clear alone: out_acc <= 0, out_sat <= 0
//   - clear with a transfer out in the same cycle: out_acc <= out_count, out_sat <= 0
//     (the new word is counted after the clear)
//   - clear has no effect on pipeline contents
//   - rst has priority over clear
//  Width rules:
//   - partial sums are CNT_W bits unsigned; no overflow possible
//   - accumulator add is done at ACC_WIDTH+1 bits, then clamped
// TESTING (IN_WIDTH=5, PATTERN=5'b10101, CHUNK=2, ACC_WIDTH=4, STAGES=3 unless noted)
//  1. in_data=5'b11111 single word, out_ready=1 -> out_valid exactly 3 cycles later,
//     out_count=3, out_acc=3 the cycle after
//  2. back-to-back 5'b00001, 5'b10100, 5'b01010, out_ready=1 ->
//     counts 1,2,0 on consecutive cycles; out_acc ends at 3
//  3. stream 5'b11111 continuously -> out_acc 3,6,9,12,15 then holds 15;
//     out_sat=1 from the transfer reaching 15
//     - clear -> out_acc=0, out_sat=0
//  4. out_ready=0 for 5 cycles with pipeline full -> in_ready=0, out_count held;
//     release -> words emerge in order, none lost
//  5. clear with a transfer out of count 2 in the same cycle -> out_acc=2, out_sat=0
//  6. rst asserted mid-stream with 3 words in flight -> next cycle out_valid=0,
//     out_acc=0, in_ready=1
//     - IN_WIDTH=32, PATTERN=all ones, CHUNK=8: 32'hFFFFFFFF -> out_count=32 after 4 cycles

Source files
------------

// File: rtl/masked_popcount_pipe.sv
// Streaming masked popcount: each word is ANDed with PATTERN and its ones are counted
// CHUNK bits per pipeline stage; delivered counts feed a saturating running total.
module masked_popcount_pipe #(
    parameter int                  IN_WIDTH  = 32,
    parameter logic [IN_WIDTH-1:0] PATTERN   = {IN_WIDTH{1'b1}},
    parameter int                  CHUNK     = 8,
    parameter int                  ACC_WIDTH = 16,
    localparam int                 STAGES    = (IN_WIDTH + CHUNK - 1) / CHUNK,
    localparam int                 CNT_W     = $clog2(IN_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     out_count,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic                 out_sat
);

    // Handshake: a word moves on a cycle where valid and ready are both high; the
    // whole pipeline shifts together whenever the last stage is empty or drained.

    localparam logic [ACC_WIDTH:0] ACC_MAX = {1'b0, {ACC_WIDTH{1'b1}}};

    logic [STAGES-1:0]   valid_q;
    logic [IN_WIDTH-1:0] word_q [STAGES];
    logic [CNT_W-1:0]    sum_q  [STAGES];
    logic                advance;
    logic [IN_WIDTH-1:0] masked_in;
    logic [ACC_WIDTH:0]  acc_sum;
    logic                xfer_out;

    // Bits beyond IN_WIDTH in a short final chunk simply never match k.
    function automatic logic [CNT_W-1:0] chunk_ones(input logic [IN_WIDTH-1:0] w, input int k);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (((i / CHUNK) == k) && w[i]) c = c + CNT_W'(1);
        end
        return c;
    endfunction

    assign advance   = !valid_q[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign masked_in = in_data & PATTERN;
    assign out_valid = valid_q[STAGES-1];
    assign out_count = sum_q[STAGES-1];
    assign xfer_out  = out_valid && out_ready;
    assign acc_sum   = {1'b0, out_acc} + (ACC_WIDTH + 1)'(out_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                word_q[k] <= '0;
                sum_q[k]  <= '0;
            end
        end else if (advance) begin
            valid_q[0] <= in_valid;
            word_q[0]  <= masked_in;
            sum_q[0]   <= chunk_ones(masked_in, 0);
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
                word_q[k]  <= word_q[k-1];
                sum_q[k]   <= sum_q[k-1] + chunk_ones(word_q[k-1], k);
            end
        end
    end

    // A clear coinciding with a delivery restarts the total from that word's count.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_acc <= '0;
            out_sat <= 1'b0;
        end else if (clear) begin
            out_acc <= xfer_out ? ACC_WIDTH'(out_count) : '0;
            out_sat <= 1'b0;
        end else if (xfer_out) begin
            if (acc_sum >= ACC_MAX) begin
                out_acc <= ACC_MAX[ACC_WIDTH-1:0];
                out_sat <= 1'b1;
            end else begin
                out_acc <= acc_sum[ACC_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_masked_popcount_pipe.sv
// Directed bench for masked_popcount_pipe: small 5-bit configuration plus a 32-bit instance.
module tb_masked_popcount_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_data;
    logic       clear;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_count;
    logic [3:0] out_acc;
    logic       out_sat;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [31:0] w_in_data;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [5:0]  w_out_count;
    logic [15:0] w_out_acc;
    logic        w_out_sat;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    masked_popcount_pipe #(
        .IN_WIDTH(5), .PATTERN(5'b10101), .CHUNK(2), .ACC_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .clear(clear), .out_valid(out_valid),
        .out_ready(out_ready), .out_count(out_count), .out_acc(out_acc),
        .out_sat(out_sat)
    );

    masked_popcount_pipe #(
        .IN_WIDTH(32), .PATTERN(32'hFFFF_FFFF), .CHUNK(8), .ACC_WIDTH(16)
    ) dut_wide (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data(w_in_data), .clear(1'b0), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_count(w_out_count), .out_acc(w_out_acc),
        .out_sat(w_out_sat)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_data = '0; w_out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_acc !== 4'd0) begin failures++; $display("FAIL reset_out_acc got=%0d exp=0", out_acc); end
        checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL reset_out_sat got=%0b exp=0", out_sat); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 5'b11111;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid cyc=%0d got=%0b exp=0", i, out_valid); end
            step();
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
        checks++; if (out_count !== 3'd3) begin failures++; $display("FAIL single_count got=%0d exp=3", out_count); end
        step();
        checks++; if (out_acc !== 4'd3) begin failures++; $display("FAIL single_acc got=%0d exp=3", out_acc); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_no_dup got=%0b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] words [3];
        logic [2:0] exp_cnt [3];
        words = '{5'b00001, 5'b10100, 5'b01010};
        exp_cnt = '{3'd1, 3'd2, 3'd0};
        do_clear();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = words[i];
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_count !== exp_cnt[i]) begin
                failures++; $display("FAIL b2b_count idx=%0d got=%0b/%0d exp=1/%0d", i, out_valid, out_count, exp_cnt[i]);
            end
            step();
        end
        checks++; if (out_acc !== 4'd3) begin failures++; $display("FAIL b2b_acc got=%0d exp=3", out_acc); end
        checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL b2b_sat got=%0b exp=0", out_sat); end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_acc [7];
        logic       exp_sat [7];
        exp_acc = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd15, 4'd15};
        exp_sat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_clear();
        in_valid = 1'b1; in_data = 5'b11111;
        step(); step(); step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sat_stream_valid got=%0b exp=1", out_valid); end
        for (int i = 0; i < 7; i++) begin
            step();
            checks++; if (out_acc !== exp_acc[i] || out_sat !== exp_sat[i]) begin
                failures++; $display("FAIL sat_acc idx=%0d got=%0d/%0b exp=%0d/%0b", i, out_acc, out_sat, exp_acc[i], exp_sat[i]);
            end
        end
        in_valid = 1'b0;
        step(); step(); step(); step();
        checks++; if (out_acc !== 4'd15 || out_sat !== 1'b1) begin failures++; $display("FAIL sat_hold got=%0d/%0b exp=15/1", out_acc, out_sat); end
        do_clear();
        checks++; if (out_acc !== 4'd0 || out_sat !== 1'b0) begin failures++; $display("FAIL sat_clear got=%0d/%0b exp=0/0", out_acc, out_sat); end
    endtask

    task automatic test_stall();
        logic [4:0] words [4];
        logic [2:0] exp_cnt [3];
        words = '{5'b10101, 5'b00001, 5'b00101, 5'b00000};
        exp_cnt = '{3'd1, 3'd2, 3'd0};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = words[i];
            step();
        end
        in_data = words[3];
        for (int i = 0; i < 5; i++) begin
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_count !== 3'd3) begin
                failures++; $display("FAIL stall_hold cyc=%0d got=rdy%0b/v%0b/%0d exp=rdy0/v1/3", i, in_ready, out_valid, out_count);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready got=%0b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_count !== exp_cnt[i]) begin
                failures++; $display("FAIL stall_order idx=%0d got=%0b/%0d exp=1/%0d", i, out_valid, out_count, exp_cnt[i]);
            end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_drain got=%0b exp=0", out_valid); end
        checks++; if (out_acc !== 4'd6) begin failures++; $display("FAIL stall_acc got=%0d exp=6", out_acc); end
    endtask

    task automatic test_clear_with_transfer();
        in_valid = 1'b1; in_data = 5'b00101;
        step();
        in_valid = 1'b0;
        step(); step();
        checks++; if (out_valid !== 1'b1 || out_count !== 3'd2) begin failures++; $display("FAIL clrx_head got=%0b/%0d exp=1/2", out_valid, out_count); end
        do_clear();
        checks++; if (out_acc !== 4'd2 || out_sat !== 1'b0) begin failures++; $display("FAIL clrx_acc got=%0d/%0b exp=2/0", out_acc, out_sat); end
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1; in_data = 5'b11111;
        step(); step(); step();
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_acc !== 4'd0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL midrst got=v%0b/acc%0d/rdy%0b exp=v0/acc0/rdy1", out_valid, out_acc, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_discard cyc=%0d got=%0b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_wide();
        w_in_valid = 1'b1; w_in_data = 32'hFFFF_FFFF;
        step();
        w_in_valid = 1'b0;
        step(); step();
        checks++; if (w_out_valid !== 1'b0) begin failures++; $display("FAIL wide_early got=%0b exp=0", w_out_valid); end
        step();
        checks++; if (w_out_valid !== 1'b1 || w_out_count !== 6'd32) begin failures++; $display("FAIL wide_count got=%0b/%0d exp=1/32", w_out_valid, w_out_count); end
        step();
        checks++; if (w_out_acc !== 16'd32) begin failures++; $display("FAIL wide_acc got=%0d exp=32", w_out_acc); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_saturate();
        test_stall();
        test_clear_with_transfer();
        test_reset_midstream();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
